// File: rtl/r30_stream_gen.sv
// rtl/r30_stream_gen.sv - rule-30 state register and center-column word generator
// Steps an external combinational rule-30 array and packs center-column bits into words.
module r30_stream_gen #(
   parameter int N      = 128,
   parameter int W      = 32,
   parameter int WARMUP = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         seed_valid,
   input  logic [N-1:0] seed_data,
   output logic [N-1:0] state_q,
   input  logic [N-1:0] state_next,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         busy
);

   localparam int BCW = $clog2(W + 1);
   localparam int WCW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
   localparam logic [BCW-1:0] BIT_LAST  = BCW'(W - 1);
   localparam logic [WCW-1:0] WARM_LAST = WCW'((WARMUP > 0) ? WARMUP - 1 : 0);
   localparam logic [N-1:0]   ONE_HOT   = N'(1) << (N / 2);

   typedef enum logic [1:0] {IDLE, WARM, FILL, HOLD} fsm_e;

   fsm_e           fsm_q, fsm_d;
   logic [N-1:0]   cells_q, cells_d;
   logic [W-1:0]   acc_q, acc_d;
   logic [W-1:0]   data_q, data_d;
   logic           valid_q, valid_d;
   logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
   logic [WCW-1:0] warm_cnt_q, warm_cnt_d;
   logic [N-1:0]   seed_eff;
   logic [W-1:0]   shift_w;

   // All-zero is a fixed point of rule 30, so it is replaced by a single live cell.
   assign seed_eff = (seed_data == '0) ? ONE_HOT : seed_data;
   assign shift_w  = (acc_q << 1) | W'(cells_q[N/2]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q      <= IDLE;
         cells_q    <= '0;
         acc_q      <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         bit_cnt_q  <= '0;
         warm_cnt_q <= '0;
      end else begin
         fsm_q      <= fsm_d;
         cells_q    <= cells_d;
         acc_q      <= acc_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         bit_cnt_q  <= bit_cnt_d;
         warm_cnt_q <= warm_cnt_d;
      end
   end

   always_comb begin
      fsm_d      = fsm_q;
      cells_d    = cells_q;
      acc_d      = acc_q;
      data_d     = data_q;
      valid_d    = valid_q;
      bit_cnt_d  = bit_cnt_q;
      warm_cnt_d = warm_cnt_q;
      // A seed overrides everything, including a handshake in the same cycle.
      if (seed_valid) begin
         cells_d    = seed_eff;
         acc_d      = '0;
         valid_d    = 1'b0;
         bit_cnt_d  = '0;
         warm_cnt_d = '0;
         fsm_d      = (WARMUP > 0) ? WARM : FILL;
      end else begin
         case (fsm_q)
            WARM: begin
               cells_d = state_next;
               if (warm_cnt_q == WARM_LAST) begin
                  warm_cnt_d = '0;
                  fsm_d      = FILL;
               end else begin
                  warm_cnt_d = warm_cnt_q + WCW'(1);
               end
            end
            FILL: begin
               cells_d = state_next;
               acc_d   = shift_w;
               if (bit_cnt_q == BIT_LAST) begin
                  data_d    = shift_w;
                  valid_d   = 1'b1;
                  acc_d     = '0;
                  bit_cnt_d = '0;
                  fsm_d     = HOLD;
               end else begin
                  bit_cnt_d = bit_cnt_q + BCW'(1);
               end
            end
            HOLD: begin
               if (out_ready) begin
                  valid_d = 1'b0;
                  fsm_d   = FILL;
               end
            end
            default: ;
         endcase
      end
   end

   assign state_q   = cells_q;
   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign busy      = (fsm_q != IDLE);

endmodule
